// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read port, frame config and serial line bundle for fifo_uart_tx
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    // FIFO read side: head word, empty flag and pop strobe
    logic                  EMPTY;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  R_INC;

    // Frame configuration, sampled at each load
    logic                  PAR_EN;
    logic                  PAR_TYP;

    // Serial line and activity flag
    logic                  TX_OUT;
    logic                  BUSY;

    // Upstream side: the FIFO and configuration source
    modport master (
        output EMPTY,
        output RD_DATA,
        output PAR_EN,
        output PAR_TYP,
        input  R_INC,
        input  TX_OUT,
        input  BUSY
    );

    // Transmitter side
    modport slave (
        input  EMPTY,
        input  RD_DATA,
        input  PAR_EN,
        input  PAR_TYP,
        output R_INC,
        output TX_OUT,
        output BUSY
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-draining UART transmitter, one CLK cycle per bit
module fifo_uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    fifo_uart_tx_if.slave bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q;
    logic [2:0]            state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  par_en_q;
    logic                  par_en_d;
    logic                  par_bit_q;
    logic                  par_bit_d;
    logic                  tx_q;
    logic                  tx_d;
    logic                  load;

    // A new word may be taken from idle, or during the stop bit so frames abut
    assign load = ((state_q == S_IDLE) || (state_q == S_STOP)) && !bus.EMPTY;

    // Pop strobe; suppressed while reset is held even if the old state would allow it
    assign bus.R_INC  = load && !RST;
    assign bus.TX_OUT = tx_q;
    assign bus.BUSY   = (state_q != S_IDLE);

    // Next-state, shift and configuration latch logic; line level follows the next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        case (state_q)
            S_IDLE, S_STOP: begin
                if (load) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    shift_d   = bus.RD_DATA;
                    par_en_d  = bus.PAR_EN;
                    // Parity is fixed at load so the shifting register need not keep the word
                    par_bit_d = (^bus.RD_DATA) ^ bus.PAR_TYP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_DATA;
                cnt_d   = '0;
            end
            S_DATA: begin
                shift_d = shift_q >> 1;
                if (cnt_q == LAST_BIT) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State, data and line registers; reset returns the line high and drops any frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed table-driven bench for fifo_uart_tx
module tb_fifo_uart_tx;
    logic CLK;
    logic RST;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) bus ();

    fifo_uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        int          len;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs [5];

    int passed = 0;
    int total  = 0;
    int pops   = 0;
    int bad    = 0;
    logic prev_rinc = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Pop-protocol watcher, sampled late in each low phase
    always @(negedge CLK) begin
        #3;
        if (bus.R_INC === 1'b1) begin
            pops++;
            if (bus.EMPTY !== 1'b0 || RST !== 1'b0) bad++;
            if (prev_rinc === 1'b1) bad++;
        end
        prev_rinc = bus.R_INC;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        logic [29:0] b2b;
        logic [20:0] ptog;
        logic [9:0]  f_c3;
        logic [9:0]  f_5a;
        int          p0;

        // Frames written first-bit-on-line at the MSB: start, D0..D7, [parity], stop
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, 11'b0_0101001011};
        vecs[1] = '{8'h0F, 1'b1, 1'b0, 11, 11'b0_11110000_0_1};
        vecs[2] = '{8'h0F, 1'b1, 1'b1, 11, 11'b0_11110000_1_1};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 11, 11'b0_00111100_1_1};
        vecs[4] = '{8'h07, 1'b1, 1'b0, 11, 11'b0_11100000_1_1};
        b2b  = {10'b0100000001, 10'b0000000011, 10'b0111111111};
        ptog = {11'b0_11110000_0_1, 10'b0_10101010_1};
        f_c3 = 10'b0_11000011_1;
        f_5a = 10'b0_01011010_1;

        RST         = 1'b1;
        bus.EMPTY   = 1'b1;
        bus.RD_DATA = 8'h00;
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;

        // Reset values, then a long empty stretch
        tick(); tick(); #1;
        chk("rst_tx", bus.TX_OUT, 1'b1);
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_rinc", bus.R_INC, 1'b0);
        tick(); RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            chk("empty_tx", bus.TX_OUT, 1'b1);
            chk("empty_busy", bus.BUSY, 1'b0);
            chk("empty_rinc", bus.R_INC, 1'b0);
        end

        // Single frames from the table
        for (int v = 0; v < 5; v++) begin
            p0 = pops;
            tick();
            bus.RD_DATA = vecs[v].data;
            bus.PAR_EN  = vecs[v].par_en;
            bus.PAR_TYP = vecs[v].par_typ;
            bus.EMPTY   = 1'b0;
            #1;
            chk("load_rinc", bus.R_INC, 1'b1);
            for (int i = 0; i < vecs[v].len; i++) begin
                tick();
                if (i == 0) bus.EMPTY = 1'b1;
                #1;
                chk($sformatf("vec%0d_bit%0d", v, i), bus.TX_OUT, vecs[v].frame[vecs[v].len-1-i]);
                chk($sformatf("vec%0d_busy%0d", v, i), bus.BUSY, 1'b1);
                chk($sformatf("vec%0d_rinc%0d", v, i), bus.R_INC, 1'b0);
            end
            tick(); #1;
            chk("vec_idle_tx", bus.TX_OUT, 1'b1);
            chk("vec_idle_busy", bus.BUSY, 1'b0);
            chk("vec_pops", pops - p0, 1);
        end

        // Three abutting frames, next word popped in each stop cycle
        p0 = pops;
        tick();
        bus.PAR_EN  = 1'b0;
        bus.RD_DATA = 8'h01;
        bus.EMPTY   = 1'b0;
        #1;
        chk("b2b_rinc_first", bus.R_INC, 1'b1);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 0)  bus.RD_DATA = 8'h80;
            if (i == 10) bus.RD_DATA = 8'hFF;
            if (i == 20) bus.EMPTY = 1'b1;
            #1;
            chk($sformatf("b2b_bit%0d", i), bus.TX_OUT, b2b[29-i]);
            chk($sformatf("b2b_busy%0d", i), bus.BUSY, 1'b1);
            chk($sformatf("b2b_rinc%0d", i), bus.R_INC, (i == 9 || i == 19) ? 1'b1 : 1'b0);
        end
        tick(); #1;
        chk("b2b_idle_tx", bus.TX_OUT, 1'b1);
        chk("b2b_idle_busy", bus.BUSY, 1'b0);
        chk("b2b_pops", pops - p0, 3);

        // Parity enable dropped mid-data: current frame keeps parity, next one does not
        tick();
        bus.RD_DATA = 8'h0F;
        bus.PAR_EN  = 1'b1;
        bus.PAR_TYP = 1'b0;
        bus.EMPTY   = 1'b0;
        #1;
        chk("ptog_rinc_first", bus.R_INC, 1'b1);
        for (int i = 0; i < 21; i++) begin
            tick();
            if (i == 0)  bus.RD_DATA = 8'h55;
            if (i == 3)  bus.PAR_EN = 1'b0;
            if (i == 11) bus.EMPTY = 1'b1;
            #1;
            chk($sformatf("ptog_bit%0d", i), bus.TX_OUT, ptog[20-i]);
            chk($sformatf("ptog_rinc%0d", i), bus.R_INC, (i == 10) ? 1'b1 : 1'b0);
        end
        tick(); #1;
        chk("ptog_idle_busy", bus.BUSY, 1'b0);

        // Reset at the fourth data bit with another word waiting
        tick();
        bus.RD_DATA = 8'hC3;
        bus.EMPTY   = 1'b0;
        #1;
        chk("rmid_rinc_first", bus.R_INC, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) bus.RD_DATA = 8'h5A;
            #1;
            chk($sformatf("rmid_bit%0d", i), bus.TX_OUT, f_c3[9-i]);
        end
        tick(); RST = 1'b1; #1;
        chk("rmid_d3", bus.TX_OUT, f_c3[5]);
        chk("rmid_rinc_rst0", bus.R_INC, 1'b0);
        tick(); #1;
        chk("rmid_tx_after", bus.TX_OUT, 1'b1);
        chk("rmid_busy_after", bus.BUSY, 1'b0);
        chk("rmid_rinc_rst1", bus.R_INC, 1'b0);
        tick(); #1;
        chk("rmid_rinc_rst2", bus.R_INC, 1'b0);
        tick(); RST = 1'b0; #1;
        chk("rmid_rinc_release", bus.R_INC, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) bus.EMPTY = 1'b1;
            #1;
            chk($sformatf("rmid_pend_bit%0d", i), bus.TX_OUT, f_5a[9-i]);
            chk($sformatf("rmid_pend_busy%0d", i), bus.BUSY, 1'b1);
        end
        tick(); #1;
        chk("rmid_idle_tx", bus.TX_OUT, 1'b1);
        chk("rmid_idle_busy", bus.BUSY, 1'b0);

        tick(); tick();
        chk("pop_protocol", bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
